// File: rtl/instr_decoder_pipe_pkg.sv
// Shared types and field layout for the buffered instruction decoder.
// Field widths live here so the decoder, its buffer and any reference model
// agree on one layout. Optional feature macro: INSTR_DECODER_ILLEGAL_CNT_EN.
package instr_decoder_pipe_pkg;

    localparam int GRP_W     = 4;
    localparam int REG_IDX_W = 4;
    localparam int OPER_W    = 4;
    localparam int IMM_W     = 16;
    localparam int INSTR_W   = GRP_W + 2*REG_IDX_W + OPER_W + IMM_W;
    localparam int FILL_W    = IMM_W - REG_IDX_W;

    // Bit positions, MSB first: group, ra, rb, then the group-specific tail.
    localparam int RA_LSB    = INSTR_W - GRP_W - REG_IDX_W;
    localparam int RB_LSB    = RA_LSB - REG_IDX_W;
    localparam int RC_LSB    = RB_LSB - REG_IDX_W;
    localparam int FILL_LSB  = OPER_W;
    localparam int OP1_LSB   = IMM_W;

    typedef enum logic [1:0] {
        GRP_0 = 2'd0,
        GRP_1 = 2'd1,
        GRP_2 = 2'd2,
        GRP_3 = 2'd3
    } grp_e;

    typedef struct packed {
        grp_e                 group;
        logic [REG_IDX_W-1:0] ra;
        logic [REG_IDX_W-1:0] rb;
        logic [REG_IDX_W-1:0] rc;
        logic [OPER_W-1:0]    opcode;
        logic [IMM_W-1:0]     imm_val;
    } decoded_t;

    typedef struct packed {
        logic     illegal;
        decoded_t dec;
    } port_out_instr_decoder_t;

    // Split a raw word into fields. Unknown groups decode to all-zero fields
    // so downstream never sees garbage register indices.
    function automatic port_out_instr_decoder_t decode_instr(input logic [INSTR_W-1:0] w);
        port_out_instr_decoder_t r;
        logic [GRP_W-1:0]        g;
        logic [FILL_W-1:0]       fill;
        r    = '0;
        g    = w[INSTR_W-1 -: GRP_W];
        fill = w[FILL_LSB +: FILL_W];
        if (g >= GRP_W'(4)) begin
            r.illegal = 1'b1;
        end else begin
            r.dec.group = grp_e'(g[1:0]);
            r.dec.ra    = w[RA_LSB +: REG_IDX_W];
            r.dec.rb    = w[RB_LSB +: REG_IDX_W];
            if (g == GRP_W'(1)) begin
                r.dec.opcode  = w[OP1_LSB +: OPER_W];
                r.dec.imm_val = w[0 +: IMM_W];
            end else begin
                r.dec.rc      = w[RC_LSB +: REG_IDX_W];
                r.dec.opcode  = w[0 +: OPER_W];
                r.illegal     = (fill != '0);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_decoder_pipe_if.sv
// Fetch-side and register-read-side handshake bundle for the decoder.
// master: the decoder itself; slave: the surrounding pipeline.
interface instr_decoder_pipe_if;
    import instr_decoder_pipe_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    decoded_t           out_decoded;
    logic               out_illegal;

    modport master (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_decoded, out_illegal
    );

    modport slave (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_decoded, out_illegal
    );
endinterface

// File: rtl/instr_decoder_pipe_fifo.sv
// Generic DEPTH x WIDTH buffer with occupancy count and synchronous flush.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module instr_decoder_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             wr_en;
    logic             rd_en;

    // Flush and reset suppress both sides so a same-cycle pop cannot advance.
    assign wr_en = push && !full && !flush && !reset;
    assign rd_en = pop && !empty && !flush && !reset;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign rdata = mem[rd_ptr];

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking with reset over flush priority.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/instr_decoder_pipe.sv
// Buffered instruction decoder: decodes groups 0-3 on the way in, flags
// illegal encodings and queues results for the register-read stage.
// Optional INSTR_DECODER_ILLEGAL_CNT_EN adds a saturating illegal-push counter.
module instr_decoder_pipe
    import instr_decoder_pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    instr_decoder_pipe_if.master       bus,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef INSTR_DECODER_ILLEGAL_CNT_EN
    ,
    output logic [15:0]                illegal_cnt
`endif
);
    port_out_instr_decoder_t dec_in;
    port_out_instr_decoder_t head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;

    assign dec_in = decode_instr(bus.in_instr);

    // No bypass: a full buffer refuses input even when the head is leaving.
    assign bus.in_ready  = !fifo_full && !flush && !reset;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.out_valid   = !fifo_empty;
    assign bus.out_decoded = fifo_empty ? '0 : head.dec;
    assign bus.out_illegal = !fifo_empty && head.illegal;

    instr_decoder_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(port_out_instr_decoder_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (dec_in),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

`ifdef INSTR_DECODER_ILLEGAL_CNT_EN
    // Count accepted illegal words; survives flush, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_cnt <= '0;
        end else if (push && dec_in.illegal && (illegal_cnt != 16'hFFFF)) begin
            illegal_cnt <= illegal_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Directed bench for instr_decoder_pipe (DEPTH=2); honours INSTR_DECODER_ILLEGAL_CNT_EN.
module tb_instr_decoder_pipe;
    import instr_decoder_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  count;
`ifdef INSTR_DECODER_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif
    int checks = 0;
    int errors = 0;
    decoded_t exp;

    instr_decoder_pipe_if bus();

    instr_decoder_pipe #(.DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus),
        .count (count)
`ifdef INSTR_DECODER_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'h0123_0005; bus.out_ready = 1'b0;
        tick; tick;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", bus.out_valid); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        checks++; if (bus.out_decoded !== decoded_t'('0)) begin errors++; $display("FAIL rst_decoded got %h exp 0", bus.out_decoded); end
        checks++; if (bus.out_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %0b exp 0", bus.out_illegal); end
`ifdef INSTR_DECODER_ILLEGAL_CNT_EN
        checks++; if (illegal_cnt !== 16'd0) begin errors++; $display("FAIL rst_illegal_cnt got %0d exp 0", illegal_cnt); end
`endif
        reset = 1'b0; bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b exp 1", bus.in_ready); end
    endtask

    task automatic test_group0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h0123_0005;
        tick;
        bus.in_valid = 1'b0;
        #1;
        exp = '{group: GRP_0, ra: 4'h1, rb: 4'h2, rc: 4'h3, opcode: 4'h5, imm_val: 16'h0};
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL g0_out_valid got %0b exp 1", bus.out_valid); end
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL g0_count got %0d exp 1", count); end
        checks++; if (bus.out_decoded !== exp) begin errors++; $display("FAIL g0_decoded got %h exp %h", bus.out_decoded, exp); end
        checks++; if (bus.out_illegal !== 1'b0) begin errors++; $display("FAIL g0_illegal got %0b exp 0", bus.out_illegal); end
        tick;
        checks++; if (bus.out_decoded !== exp) begin errors++; $display("FAIL g0_hold got %h exp %h", bus.out_decoded, exp); end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        #1;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL g0_pop_count got %0d exp 0", count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL g0_pop_valid got %0b exp 0", bus.out_valid); end
    endtask

    task automatic test_group1;
        bus.in_valid = 1'b1; bus.in_instr = 32'h1452_ABCD;
        tick;
        bus.in_valid = 1'b0;
        #1;
        exp = '{group: GRP_1, ra: 4'h4, rb: 4'h5, rc: 4'h0, opcode: 4'h2, imm_val: 16'hABCD};
        checks++; if (bus.out_decoded !== exp) begin errors++; $display("FAIL g1_decoded got %h exp %h", bus.out_decoded, exp); end
        checks++; if (bus.out_illegal !== 1'b0) begin errors++; $display("FAIL g1_illegal got %0b exp 0", bus.out_illegal); end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        #1;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL g1_pop_count got %0d exp 0", count); end
    endtask

    task automatic test_illegal;
        bus.in_valid = 1'b1; bus.in_instr = 32'h2123_0105;
        tick;
        bus.in_instr = 32'h9000_0000;
        tick;
        bus.in_valid = 1'b0;
        #1;
        exp = '{group: GRP_2, ra: 4'h1, rb: 4'h2, rc: 4'h3, opcode: 4'h5, imm_val: 16'h0};
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL ill_count got %0d exp 2", count); end
        checks++; if (bus.out_illegal !== 1'b1) begin errors++; $display("FAIL ill_fill_flag got %0b exp 1", bus.out_illegal); end
        checks++; if (bus.out_decoded !== exp) begin errors++; $display("FAIL ill_fill_decoded got %h exp %h", bus.out_decoded, exp); end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.out_illegal !== 1'b1) begin errors++; $display("FAIL ill_grp_flag got %0b exp 1", bus.out_illegal); end
        checks++; if (bus.out_decoded !== decoded_t'('0)) begin errors++; $display("FAIL ill_grp_decoded got %h exp 0", bus.out_decoded); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ill_grp_valid got %0b exp 1", bus.out_valid); end
`ifdef INSTR_DECODER_ILLEGAL_CNT_EN
        checks++; if (illegal_cnt !== 16'd2) begin errors++; $display("FAIL ill_cnt got %0d exp 2", illegal_cnt); end
`endif
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        #1;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL ill_drain_count got %0d exp 0", count); end
    endtask

    task automatic test_back_to_back;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h0123_0005;
        tick;
        bus.in_instr = 32'h0456_0007;
        tick;
        bus.in_instr = 32'h1789_1234;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %0b exp 0", bus.in_ready); end
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL b2b_full_count got %0d exp 2", count); end
        tick;
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL b2b_third_count got %0d exp 2", count); end
        checks++; if (bus.out_decoded.ra !== 4'h1) begin errors++; $display("FAIL b2b_head_a got ra %0h exp 1", bus.out_decoded.ra); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_bypass got %0b exp 0", bus.in_ready); end
        tick;
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL b2b_pop_count got %0d exp 1", count); end
        checks++; if (bus.out_decoded.ra !== 4'h4) begin errors++; $display("FAIL b2b_head_b got ra %0h exp 4", bus.out_decoded.ra); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_again got %0b exp 1", bus.in_ready); end
        tick;
        bus.in_valid = 1'b0;
        #1;
        exp = '{group: GRP_1, ra: 4'h7, rb: 4'h8, rc: 4'h0, opcode: 4'h9, imm_val: 16'h1234};
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL b2b_pushpop_count got %0d exp 1", count); end
        checks++; if (bus.out_decoded !== exp) begin errors++; $display("FAIL b2b_head_c got %h exp %h", bus.out_decoded, exp); end
        tick;
        bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid got %0b exp 0", bus.out_valid); end
    endtask

    task automatic test_flush;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h0123_0005;
        tick;
        bus.in_instr = 32'h0456_0007;
        tick;
        flush = 1'b1; bus.in_instr = 32'h1789_1234; bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready got %0b exp 0", bus.in_ready); end
        tick;
        flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL fl_count got %0d exp 0", count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_out_valid got %0b exp 0", bus.out_valid); end
        checks++; if (bus.out_decoded !== decoded_t'('0)) begin errors++; $display("FAIL fl_decoded got %h exp 0", bus.out_decoded); end
        tick;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL fl_not_stored got %0d exp 0", count); end
`ifdef INSTR_DECODER_ILLEGAL_CNT_EN
        checks++; if (illegal_cnt !== 16'd2) begin errors++; $display("FAIL fl_cnt_kept got %0d exp 2", illegal_cnt); end
`endif
    endtask

    task automatic test_reset_mid;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h0123_0005;
        tick;
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL rm_pre_count got %0d exp 1", count); end
        reset = 1'b1; bus.in_instr = 32'h0456_0007;
        tick;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL rm_count got %0d exp 0", count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %0b exp 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rm_in_ready got %0b exp 0", bus.in_ready); end
        checks++; if (bus.out_decoded !== decoded_t'('0)) begin errors++; $display("FAIL rm_decoded got %h exp 0", bus.out_decoded); end
        checks++; if (bus.out_illegal !== 1'b0) begin errors++; $display("FAIL rm_illegal got %0b exp 0", bus.out_illegal); end
`ifdef INSTR_DECODER_ILLEGAL_CNT_EN
        checks++; if (illegal_cnt !== 16'd0) begin errors++; $display("FAIL rm_illegal_cnt got %0d exp 0", illegal_cnt); end
`endif
        reset = 1'b0; bus.in_valid = 1'b0;
        tick;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL rm_after_count got %0d exp 0", count); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_group0();
        test_group1();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
